u_nb_addsub_seq: RTL and testbench
==================================

Name: u_nb_addsub_seq

Overview:
- Parametrised, multi-cycle unsigned/two's-complement add/subtract unit; the successor to the fixed 32-bit combinational subtractor.
- Processes operands SLICE bits per clock, with a registered carry chain, to cut the critical path at large WIDTH.
- Valid/ready handshake on input and output so the unit sits inside datapath pipelines.
- Produces result, carry/borrow, zero and signed-overflow flags.

Parameters:
- WIDTH, 32, operand and result width; must be a multiple of SLICE.
- SLICE, 8, bits processed per cycle; BEATS = WIDTH/SLICE; BEATS >= 1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands and op_sub valid.
- in_ready  out  1  unit can accept an operation.
- op_sub  in  1  1 = in1 - in2, 0 = in1 + in2.
- in1  in  WIDTH  operand A.
- in2  in  WIDTH  operand B.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts result.
- diff  out  WIDTH  result, modulo 2^WIDTH.
- cb  out  1  add: carry out; sub: borrow (1 when in1 < in2, unsigned).
- zero  out  1  result == 0.
- ovf  out  1  signed two's-complement overflow.

Behaviour:
- Reset (asynchronous, any state): state = IDLE; out_valid = 0; diff = 0; cb = 0; zero = 0; ovf = 0; beat counter and carry register = 0. After reset release, in_ready = 1. Any in-flight operation is discarded.
- FSM states IDLE, CALC, DONE. in_ready = (state == IDLE), decoded from state only.
- IDLE: on in_valid && in_ready:
  - Latch in1, in2 and op_sub.
  - Set carry register = op_sub; B operand = op_sub ? ~in2 : in2.
  - Set beat counter = 0 and go to CALC.
- CALC: each cycle, add slice k of A, B and the carry register into slice k of the internal accumulator, then update the carry register.
  - Counter increments.
  - After beat BEATS-1, go to DONE.
- Output register load: on the transition into DONE, load diff, cb, zero and ovf from the final accumulator and carry; assert out_valid.
- Latency: out_valid rises exactly BEATS+1 clock edges after the accepting edge (BEATS edges of CALC plus one edge into DONE).
- DONE: out_valid = 1. diff and flags hold while out_ready = 0. On out_ready = 1, go to IDLE and deassert out_valid. A new operation is accepted no earlier than the following cycle, so there is no overlap.
- diff and flags change only when entering DONE; partial results are never visible. Values persist after the handshake until the next result.
- cb: add → final carry; sub → inverse of final carry.
- ovf: add → in1[MSB] == in2[MSB] and diff[MSB] != in1[MSB]; sub → in1[MSB] != in2[MSB] and diff[MSB] != in1[MSB].
- Input changes while not in IDLE are ignored. in_valid held high in DONE is not consumed until IDLE.
- BEATS = 1: CALC lasts a single cycle; same rules apply.

Optional Feature:
- Macro ADDSUB_SAT_EN.
- Defined: unsigned saturation applied at the DONE load.
  - Add with carry: diff = all ones.
  - Sub with borrow: diff = 0.
  - cb still reports the raw carry/borrow.
  - zero is computed on the saturated value.
  - ovf is unchanged (computed on the raw result).
- Undefined: diff wraps modulo 2^WIDTH; no saturation logic is present.

Test Plan:
- WIDTH=32, SLICE=8, sub 10 - 5 → diff=5, cb=0, zero=0, ovf=0; out_valid 5 edges after accept.
- Sub 1000 - 1010 → diff=0xFFFFFFF6, cb=1, ovf=0. With ADDSUB_SAT_EN: diff=0, cb=1, zero=1.
- Add 0xFFFFFFFF + 1 → diff=0, cb=1, zero=1, ovf=0. Add 0x7FFFFFFF + 1 → diff=0x80000000, cb=0, ovf=1.
- Sub 0x80000000 - 1 → diff=0x7FFFFFFF, cb=0, ovf=1. Sub 1073409 - 80675 → diff=992734, flags 0.
- Backpressure: hold out_ready=0 for 3 cycles in DONE → diff/flags stable, in_ready=0, new in_valid not accepted; accepted the cycle after IDLE is re-entered.
- Assert rst_n=0 mid-CALC (beat 2) → out_valid=0, diff=0 immediately. After release, in_ready=1, and a fresh 100 - 99 yields diff=1.

Source files
------------

// File: rtl/u_nb_addsub_seq_if.sv
// ---------------------------------------------------------------------------
// u_nb_addsub_seq_if
// Handshake and data bundle for the sliced add/subtract unit.
//
// Parameters:
//   WIDTH     operand/result width
//
// Signals:
//   in_valid   producer -> unit   operands and op_sub valid
//   in_ready   unit -> producer   unit can accept an operation
//   op_sub     producer -> unit   1 = in1 - in2, 0 = in1 + in2
//   in1, in2   producer -> unit   operands
//   out_valid  unit -> consumer   result and flags valid
//   out_ready  consumer -> unit   consumer accepts result
//   diff       unit -> consumer   result modulo 2^WIDTH
//   cb         unit -> consumer   carry (add) / borrow (sub)
//   zero       unit -> consumer   result == 0
//   ovf        unit -> consumer   signed overflow
//
// Modports:
//   master  drives operands and out_ready (producer/consumer side)
//   slave   the arithmetic unit itself
// ---------------------------------------------------------------------------
interface u_nb_addsub_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic             op_sub;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             cb;
  logic             zero;
  logic             ovf;

  modport master (
    output in_valid,
    output op_sub,
    output in1,
    output in2,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  diff,
    input  cb,
    input  zero,
    input  ovf
  );

  modport slave (
    input  in_valid,
    input  op_sub,
    input  in1,
    input  in2,
    input  out_ready,
    output in_ready,
    output out_valid,
    output diff,
    output cb,
    output zero,
    output ovf
  );
endinterface

// File: rtl/u_nb_addsub_seq.sv
// ---------------------------------------------------------------------------
// u_nb_addsub_seq
// Multi-cycle add/subtract unit. Operands are consumed SLICE bits per clock
// through a registered carry, so the carry chain in any one cycle is only
// SLICE bits long regardless of WIDTH.
//
// Parameters:
//   WIDTH  operand/result width, must be a multiple of SLICE
//   SLICE  bits processed per clock (BEATS = WIDTH/SLICE >= 1)
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; discards any in-flight operation
//   bus    u_nb_addsub_seq_if.slave: in_valid/in_ready/op_sub/in1/in2,
//          out_valid/out_ready/diff/cb/zero/ovf
//
// Compile-time option:
//   ADDSUB_SAT_EN  when defined, the result saturates (all ones on add
//                  carry, zero on subtract borrow); cb and ovf still report
//                  the raw arithmetic, zero reflects the saturated value.
//
// Timing: out_valid rises BEATS+1 edges after the accepting edge. The
// outputs only change when entering DONE and hold until the next result.
// ---------------------------------------------------------------------------
module u_nb_addsub_seq #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  u_nb_addsub_seq_if.slave bus
);

  localparam int BEATS = WIDTH / SLICE;
  // Counter must reach BEATS: BEATS slice beats plus one terminal check.
  localparam int CNT_W = $clog2(BEATS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;

  logic               accept_s;
  logic               calc_step_s;
  logic               load_s;
  logic               release_s;

  // Operand shift registers: the low slice is always the current beat.
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [WIDTH-1:0]   acc_r;
  logic               carry_r;
  logic [CNT_W-1:0]   beat_r;
  logic               op_sub_r;
  logic               a_msb_r;
  logic               b_msb_r;

  logic [SLICE:0]     sum_s;
  logic [WIDTH+SLICE-1:0] acc_shift_s;

  logic [WIDTH-1:0]   res_s;
  logic               cb_s;
  logic               zero_s;
  logic               ovf_s;

  logic [WIDTH-1:0]   diff_r;
  logic               cb_r;
  logic               zero_r;
  logic               ovf_r;
  logic               out_valid_r;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode and per-state control strobes.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    calc_step_s = 1'b0;
    load_s      = 1'b0;
    release_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.in_valid) begin
          accept_s    = 1'b1;
          state_nxt_s = CALC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CALC: begin
        // Once all BEATS slices are in, spend one edge loading the outputs.
        if (beat_r == CNT_W'(BEATS)) begin
          load_s      = 1'b1;
          state_nxt_s = DONE;
        end else begin
          calc_step_s = 1'b1;
          state_nxt_s = CALC;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          release_s   = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  assign bus.in_ready = (state_r == IDLE);

  // One slice of the ripple add; the carry-in comes from the previous beat.
  always_comb begin
    sum_s       = {1'b0, a_r[SLICE-1:0]} + {1'b0, b_r[SLICE-1:0]}
                + {{SLICE{1'b0}}, carry_r};
    // New slice enters at the top; after BEATS shifts slice 0 sits at bit 0.
    acc_shift_s = {sum_s[SLICE-1:0], acc_r};
  end

  // Operand capture and per-beat datapath advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      acc_r    <= {WIDTH{1'b0}};
      carry_r  <= 1'b0;
      beat_r   <= {CNT_W{1'b0}};
      op_sub_r <= 1'b0;
      a_msb_r  <= 1'b0;
      b_msb_r  <= 1'b0;
    end else if (accept_s) begin
      // Subtract as A + ~B + 1: invert B and seed the carry with op_sub.
      a_r      <= bus.in1;
      b_r      <= bus.op_sub ? ~bus.in2 : bus.in2;
      acc_r    <= {WIDTH{1'b0}};
      carry_r  <= bus.op_sub;
      beat_r   <= {CNT_W{1'b0}};
      op_sub_r <= bus.op_sub;
      a_msb_r  <= bus.in1[WIDTH-1];
      b_msb_r  <= bus.in2[WIDTH-1];
    end else if (calc_step_s) begin
      a_r      <= a_r >> SLICE;
      b_r      <= b_r >> SLICE;
      acc_r    <= acc_shift_s[WIDTH+SLICE-1:SLICE];
      carry_r  <= sum_s[SLICE];
      beat_r   <= beat_r + CNT_W'(1);
    end else begin
      a_r      <= a_r;
      b_r      <= b_r;
      acc_r    <= acc_r;
      carry_r  <= carry_r;
      beat_r   <= beat_r;
      op_sub_r <= op_sub_r;
      a_msb_r  <= a_msb_r;
      b_msb_r  <= b_msb_r;
    end
  end

  // Final result and flags from the completed accumulator and carry.
  always_comb begin
    // For subtract the final carry is the inverse of the borrow.
    cb_s = op_sub_r ? ~carry_r : carry_r;

    if (op_sub_r) begin
      ovf_s = (a_msb_r != b_msb_r) && (acc_r[WIDTH-1] != a_msb_r);
    end else begin
      ovf_s = (a_msb_r == b_msb_r) && (acc_r[WIDTH-1] != a_msb_r);
    end

`ifdef ADDSUB_SAT_EN
    if (!op_sub_r && carry_r) begin
      res_s = {WIDTH{1'b1}};
    end else if (op_sub_r && !carry_r) begin
      res_s = {WIDTH{1'b0}};
    end else begin
      res_s = acc_r;
    end
`else
    res_s = acc_r;
`endif

    zero_s = (res_s == {WIDTH{1'b0}});
  end

  // Output registers: loaded only on entry to DONE, held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_r      <= {WIDTH{1'b0}};
      cb_r        <= 1'b0;
      zero_r      <= 1'b0;
      ovf_r       <= 1'b0;
      out_valid_r <= 1'b0;
    end else if (load_s) begin
      diff_r      <= res_s;
      cb_r        <= cb_s;
      zero_r      <= zero_s;
      ovf_r       <= ovf_s;
      out_valid_r <= 1'b1;
    end else if (release_s) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.diff      = diff_r;
  assign bus.cb        = cb_r;
  assign bus.zero      = zero_r;
  assign bus.ovf       = ovf_r;

endmodule

// File: tb/tb_u_nb_addsub_seq.sv
// ---------------------------------------------------------------------------
// tb_u_nb_addsub_seq
// Scoreboard bench for u_nb_addsub_seq (WIDTH=32, SLICE=8). The driver pushes
// the reference result for each accepted operation; a monitor pops and
// compares whenever a new result appears, and checks it holds while stalled.
// ---------------------------------------------------------------------------
module tb_u_nb_addsub_seq;

  localparam int WIDTH = 32;
  localparam int SLICE = 8;
  localparam int BEATS = WIDTH / SLICE;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  u_nb_addsub_seq_if #(.WIDTH(WIDTH)) bus ();

  u_nb_addsub_seq #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] diff;
    logic        cb;
    logic        zero;
    logic        ovf;
    int          acc_cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   rdy_mode = 0;   // 0 random, 1 hold low, 2 hold high

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model from plain arithmetic.
  function automatic exp_t model(input bit op, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa;
    longint sb;
    longint sr;
    logic [32:0] full;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op) begin
      full = {1'b0, a} - {1'b0, b};
      e.cb = (a < b);
      sr   = sa - sb;
    end else begin
      full = {1'b0, a} + {1'b0, b};
      e.cb = full[32];
      sr   = sa + sb;
    end
    e.diff = full[31:0];
    e.ovf  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
`ifdef ADDSUB_SAT_EN
    if (e.cb) e.diff = op ? 32'h0000_0000 : 32'hFFFF_FFFF;
`endif
    e.zero    = (e.diff == 32'h0000_0000);
    e.acc_cyc = 0;
    return e;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'h0000_0001;
      default: return $urandom();
    endcase
  endfunction

  task automatic send(input bit op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   t = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op_sub   = op;
    bus.in1      = a;
    bus.in2      = b;
    while (!bus.in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("accept_wait", 64'(bus.in_ready), 64'(1));
    if (bus.in_ready) begin
      e         = model(op, a, b);
      e.acc_cyc = cyc + 1;          // cycle number of the accepting edge
      sb_q.push_back(e);
      @(negedge clk);
      chk("accepted", 64'(bus.in_ready), 64'(0));
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((sb_q.size() != 0 || bus.out_valid) && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("drain", 64'(sb_q.size()), 64'(0));
  endtask

  // Consumer readiness, applied just after each falling edge.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      case (rdy_mode)
        0:       bus.out_ready = ($urandom_range(0, 3) != 0);
        1:       bus.out_ready = 1'b0;
        default: bus.out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: compare each new result against the scoreboard head.
  initial begin : mon
    bit   prev_ov = 1'b0;
    exp_t cur;
    cur = model(1'b0, 32'h0, 32'h0);
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_ov = 1'b0;
      end else begin
        if (bus.out_valid && !prev_ov) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_result", 64'(sb_q.size()), 64'(1));
          end else begin
            cur = sb_q.pop_front();
            chk("diff",    64'(bus.diff), 64'(cur.diff));
            chk("cb",      64'(bus.cb),   64'(cur.cb));
            chk("zero",    64'(bus.zero), 64'(cur.zero));
            chk("ovf",     64'(bus.ovf),  64'(cur.ovf));
            chk("latency", 64'(cyc),      64'(cur.acc_cyc + BEATS + 1));
          end
        end else if (bus.out_valid) begin
          chk("hold_diff", 64'(bus.diff), 64'(cur.diff));
          chk("hold_cb",   64'(bus.cb),   64'(cur.cb));
          chk("hold_zero", 64'(bus.zero), 64'(cur.zero));
          chk("busy_in_ready", 64'(bus.in_ready), 64'(0));
        end
        prev_ov = bus.out_valid;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    logic [31:0] a;
    logic [31:0] b;
    bit          op;
    int          t;

    bus.in_valid = 1'b0;
    bus.op_sub   = 1'b0;
    bus.in1      = 32'h0;
    bus.in2      = 32'h0;

    // Reset state.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_diff",      64'(bus.diff),      64'(0));
    chk("rst_cb",        64'(bus.cb),        64'(0));
    chk("rst_zero",      64'(bus.zero),      64'(0));
    chk("rst_ovf",       64'(bus.ovf),       64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'(1));

    // Directed corner cases.
    rdy_mode = 2;
    send(1'b1, 32'd10,          32'd5);
    send(1'b1, 32'd1000,        32'd1010);
    send(1'b0, 32'hFFFF_FFFF,   32'd1);
    send(1'b0, 32'h7FFF_FFFF,   32'd1);
    send(1'b1, 32'h8000_0000,   32'd1);
    send(1'b1, 32'd1073409,     32'd80675);
    send(1'b1, 32'hDEAD_BEEF,   32'hDEAD_BEEF);
    send(1'b0, 32'h8000_0000,   32'h8000_0000);
    drain();

    // Randomized traffic with random backpressure.
    rdy_mode = 0;
    for (int i = 0; i < 60; i++) begin
      op = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 2) == 0) ? pick() : $urandom();
      b  = ($urandom_range(0, 2) == 0) ? pick() : $urandom();
      if ($urandom_range(0, 7) == 0) b = a;
      send(op, a, b);
    end
    drain();

    // Backpressure: stall in DONE while a new request waits.
    rdy_mode = 1;
    send(1'b0, 32'h1234_5678, 32'h1111_1111);
    t = 0;
    while (!bus.out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("bp_out_valid", 64'(bus.out_valid), 64'(1));
    bus.in_valid = 1'b1;
    bus.op_sub   = 1'b1;
    bus.in1      = 32'd500;
    bus.in2      = 32'd200;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready",  64'(bus.in_ready),  64'(0));
      chk("bp_valid_hold", 64'(bus.out_valid), 64'(1));
    end
    rdy_mode = 2;
    @(negedge clk);
    chk("bp_idle_in_ready", 64'(bus.in_ready),  64'(1));
    chk("bp_released",      64'(bus.out_valid), 64'(0));
    chk("bp_persist_diff",  64'(bus.diff),      64'(32'h2345_6789));
    e         = model(1'b1, 32'd500, 32'd200);
    e.acc_cyc = cyc + 1;
    sb_q.push_back(e);
    @(negedge clk);
    chk("bp_accepted", 64'(bus.in_ready), 64'(0));
    bus.in_valid = 1'b0;
    drain();

    // Reset during CALC discards the operation.
    send(1'b0, 32'h0000_00FF, 32'h0000_0001);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("midrst_diff",      64'(bus.diff),      64'(0));
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", 64'(bus.in_ready), 64'(1));
    send(1'b1, 32'd100, 32'd99);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
